// File: rtl/mpram_flush.sv
// mpram_flush: multi-read-port, single-write-port distributed RAM.
// A clear sequencer writes INIT_VAL to every entry after reset or FLUSH.
// While the sweep runs, every read port returns INIT_VAL.
// Optional write-first bypass from DI to read ports that hit AW.
module mpram_flush #(
  parameter int              WIDTH    = 2,
  parameter int              DEPTH    = 32,
  parameter int              RD_PORTS = 3,
  parameter int              BYPASS   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int             AWID     = $clog2(DEPTH)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WEN,
  input  logic [AWID-1:0]            AW,
  input  logic [WIDTH-1:0]           DI,
  input  logic [RD_PORTS*AWID-1:0]   RA,
  output logic [RD_PORTS*WIDTH-1:0]  Q,
  input  logic                       FLUSH,
  output logic                       BUSY
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AWID-1:0] LAST_ADDR = AWID'(DEPTH - 1);
  localparam logic [AWID:0]   DEPTH_EXT = (AWID + 1)'(DEPTH);
  localparam bit              POW2      = (DEPTH == (1 << AWID));

  state_t            state_q, state_d;
  logic [AWID-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  ram_q [DEPTH];

  logic              wr_in_range;
  logic              usr_we;
  logic              byp_en;

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
  generate
    if (POW2) begin : g_wr_pow2
      assign wr_in_range = 1'b1;
    end else begin : g_wr_npow2
      assign wr_in_range = ({1'b0, AW} < DEPTH_EXT);
    end
  endgenerate

  assign BUSY   = (state_q == CLEAR);
  // A user write lands only when idle and not being flushed this cycle.
  assign byp_en = (state_q == IDLE) && WEN && !FLUSH;
  assign usr_we = byp_en && wr_in_range;

  // State and sweep counter; reset forces a fresh sweep from entry 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: FLUSH (re)starts the sweep, sweep ends after entry DEPTH-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (FLUSH) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (FLUSH) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset: the sweep writes INIT_VAL, otherwise user writes.
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      ram_q[cnt_q] <= INIT_VAL;
    end else if (usr_we) begin
      ram_q[AW] <= DI;
    end
  end

  // Independent combinational read ports.
  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [AWID-1:0]  ra_port;
      logic [WIDTH-1:0] q_port;
      logic             rd_in_range;

      assign ra_port = RA[gi*AWID +: AWID];

      if (POW2) begin : g_rd_pow2
        assign rd_in_range = 1'b1;
      end else begin : g_rd_npow2
        assign rd_in_range = ({1'b0, ra_port} < DEPTH_EXT);
      end

      // Masking during the sweep has priority, then bypass, then the array.
      always_comb begin
        q_port = INIT_VAL;
        if (BUSY) begin
          q_port = INIT_VAL;
        end else if ((BYPASS != 0) && byp_en && (ra_port == AW)) begin
          q_port = DI;
        end else if (rd_in_range) begin
          q_port = ram_q[ra_port];
        end
      end

      assign Q[gi*WIDTH +: WIDTH] = q_port;
    end
  endgenerate

endmodule

// File: tb/tb_mpram_flush.sv
// tb_mpram_flush: three instances (bypass, read-old, non-power-of-two depth)
// driven by shared stimulus and checked every cycle against a model that
// tracks contents and the number of sweep edges still outstanding.
module tb_mpram_flush;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wen;
  logic        flush;
  logic [4:0]  aw;
  logic [7:0]  di;
  logic [19:0] ra;

  logic [5:0]  q_a, q_b;
  logic [31:0] q_c;
  logic        busy_a, busy_b, busy_c;

  mpram_flush #(.WIDTH(2), .DEPTH(32), .RD_PORTS(3), .BYPASS(1), .INIT_VAL(2'b00)) dut_a (
    .CLK(clk), .RST(rst), .WEN(wen), .AW(aw), .DI(di[1:0]), .RA(ra[14:0]),
    .Q(q_a), .FLUSH(flush), .BUSY(busy_a));

  mpram_flush #(.WIDTH(2), .DEPTH(32), .RD_PORTS(3), .BYPASS(0), .INIT_VAL(2'b00)) dut_b (
    .CLK(clk), .RST(rst), .WEN(wen), .AW(aw), .DI(di[1:0]), .RA(ra[14:0]),
    .Q(q_b), .FLUSH(flush), .BUSY(busy_b));

  mpram_flush #(.WIDTH(8), .DEPTH(20), .RD_PORTS(4), .BYPASS(1), .INIT_VAL(8'hA5)) dut_c (
    .CLK(clk), .RST(rst), .WEN(wen), .AW(aw), .DI(di), .RA(ra),
    .Q(q_c), .FLUSH(flush), .BUSY(busy_c));

  // Reference model: per-instance configuration, contents, sweep edges left.
  int dep   [3] = '{32, 32, 20};
  int wmask [3] = '{3, 3, 255};
  int initv [3] = '{0, 0, 'hA5};
  int nport [3] = '{3, 3, 4};
  int byp   [3] = '{1, 0, 1};
  int mem   [3][32];
  int left  [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_q(input int k, input int p);
    logic [31:0] r;
    r = '0;
    case (k)
      0:       r[1:0] = q_a[p*2 +: 2];
      1:       r[1:0] = q_b[p*2 +: 2];
      default: r[7:0] = q_c[p*8 +: 8];
    endcase
    return r;
  endfunction

  function automatic logic dut_busy(input int k);
    case (k)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int exp_q(input int k, input int p);
    int r;
    r = int'(ra[p*5 +: 5]);
    if (left[k] > 0) return initv[k];
    if (byp[k] != 0 && wen && !flush && r == int'(aw)) return int'(di) & wmask[k];
    if (r < dep[k]) return mem[k][r];
    return initv[k];
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    if (rst) for (int k = 0; k < 3; k++) left[k] = dep[k];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("busy k%0d", k), 32'(dut_busy(k)), 32'(left[k] > 0));
      for (int p = 0; p < nport[k]; p++)
        check_val($sformatf("q k%0d p%0d ra%0d", k, p, ra[p*5 +: 5]),
                  dut_q(k, p), 32'(exp_q(k, p)));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        left[k] = dep[k];
      end else if (left[k] > 0) begin
        if (flush) left[k] = dep[k];
        else begin
          left[k]--;
          if (left[k] == 0)
            for (int a = 0; a < 32; a++) mem[k][a] = initv[k];
        end
      end else if (flush) begin
        left[k] = dep[k];
      end else if (wen && int'(aw) < dep[k]) begin
        mem[k][aw] = int'(di) & wmask[k];
      end
    end
    #1;
  endtask

  task automatic drive(input bit r, input bit we, input int a, input int d,
                       input bit f, input logic [19:0] rr);
    rst = r; wen = we; aw = 5'(a); di = 8'(d); flush = f; ra = rr;
    step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 20'($urandom));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      left[k] = dep[k];
      for (int a = 0; a < 32; a++) mem[k][a] = initv[k];
    end
    rst = 0; wen = 0; flush = 0; aw = '0; di = '0; ra = '0;
    #2 rst = 1;

    $display("[TB] power-up reset and first sweep");
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 1, 4, 3, 0, '0);
    idle_cycles(34);

    $display("[TB] fill all entries with ones, then reset sweep");
    for (int i = 0; i < 32; i++) drive(0, 1, i, 8'hFF, 0, 20'($urandom));
    drive(1, 0, 0, 0, 0, '0);
    idle_cycles(33);
    for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 0, {4{5'(i)}});

    $display("[TB] directed write/read on three ports");
    drive(0, 1, 5, 2, 0, '0);
    drive(0, 1, 31, 1, 0, '0);
    drive(0, 0, 0, 0, 0, {5'd0, 5'd31, 5'd5, 5'd5});
    drive(0, 0, 0, 0, 0, {5'd31, 5'd0, 5'd5, 5'd5});

    $display("[TB] bypass versus read-old");
    drive(0, 1, 7, 3, 0, {5'd0, 5'd7, 5'd8, 5'd7});
    drive(0, 0, 0, 0, 0, {5'd0, 5'd7, 5'd8, 5'd7});

    $display("[TB] flush with simultaneous write, re-flush mid-sweep");
    drive(0, 1, 3, 3, 1, {15'd0, 5'd3});
    for (int i = 0; i < 10; i++) drive(0, 1, i, 8'hFF, 0, 20'($urandom));
    drive(0, 0, 0, 0, 1, '0);
    for (int i = 0; i < 34; i++) drive(0, 1, i, 8'h5A, 0, 20'($urandom));
    drive(0, 0, 0, 0, 0, {5'd3, 5'd3, 5'd3, 5'd3});

    $display("[TB] out-of-range write on depth 20");
    drive(0, 1, 25, 8'h3C, 0, {5'd25, 5'd25, 5'd19, 5'd0});
    drive(0, 0, 0, 0, 0, {5'd25, 5'd25, 5'd19, 5'd0});

    $display("[TB] reset mid-sweep");
    drive(0, 0, 0, 0, 1, '0);
    idle_cycles(12);
    drive(1, 0, 0, 0, 0, '0);
    idle_cycles(34);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 255) == 0),
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 31)),
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 63) == 0),
            20'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpram_flush.md
# mpram_flush

Parametrised multi-read-port, single-write-port distributed RAM with a hardware clear sequencer and an optional write-to-read bypass. It is the general form of the fixed 32x2 three-read-port LUTRAM used for small CPU-side tables such as predictor counters, valid/age bits and scoreboard fields. LUTRAM cannot be reset, so this block sweeps every entry to a defined value after reset or on a flush request. While the sweep runs, all readers see that cleared value.

## Interface
- WIDTH, 2, data bits per entry (>=1)
- DEPTH, 32, number of entries (>=2; need not be a power of two)
- RD_PORTS, 3, number of asynchronous read ports (>=1)
- BYPASS, 1, 1 = write-first forwarding of DI to matching read ports; 0 = read-old
- INIT_VAL, 0, WIDTH-bit value written to every entry by the clear sweep
- AWID (local), $clog2(DEPTH), address width
- CLK  in  1  sole clock; all state updates on its rising edge
- RST  in  1  asynchronous, active-high reset
- WEN  in  1  write enable
- AW  in  AWID  write address
- DI  in  WIDTH  write data
- RA  in  RD_PORTS*AWID  read addresses; port i uses RA[i*AWID +: AWID]
- Q  out  RD_PORTS*WIDTH  read data; port i drives Q[i*WIDTH +: WIDTH]
- FLUSH  in  1  single-cycle clear request
- BUSY  out  1  clear sweep in progress

## Operation
- Storage: DEPTH x WIDTH array with no reset on the array itself. The only state elements are the FSM state and the sweep counter cnt[AWID-1:0].
- FSM states:
  - IDLE: normal operation.
  - CLEAR: the sweep is running.
- RST asserted (async): state goes to CLEAR, cnt to 0, BUSY to 1. Array contents are not touched until clock edges occur.
- CLEAR, each rising edge:
  - ram[cnt] <= INIT_VAL.
  - If cnt == DEPTH-1, go to IDLE and set cnt to 0; otherwise cnt <= cnt+1.
  - The sweep counter wraps at DEPTH-1, not at 2^AWID.
- IDLE + FLUSH: go to CLEAR with cnt=0. The sweep starts on the next edge.
- CLEAR + FLUSH: cnt restarts at 0. The sweep length is counted from the last FLUSH.
- User writes:
  - Performed only in IDLE with FLUSH=0: WEN=1 gives ram[AW] <= DI.
  - In CLEAR, or in the same cycle as FLUSH, WEN is ignored and the write is dropped.
  - AW >= DEPTH (non-power-of-two DEPTH): the write is dropped.
- Reads: combinational, evaluated independently per port.
  - BUSY=1: every Q port = INIT_VAL, regardless of RA.
  - BYPASS=1, IDLE, WEN=1, FLUSH=0, RA[i]==AW: Q port i = DI.
  - Otherwise Q port i = ram[RA[i]]. RA >= DEPTH returns INIT_VAL.
- Any number of read ports may address the same entry, including AW, in the same cycle.

## Timing
- Read latency 0 cycles (combinational from RA, WEN, AW, DI, BUSY).
- Write latency: visible on a non-bypassed read from the cycle after the write edge.
- BUSY is a registered state decode. It rises asynchronously on RST, or one edge after FLUSH is sampled in IDLE.
- BUSY falls after the edge that clears entry DEPTH-1, which is exactly DEPTH edges after the sweep starts.
  - After reset release with no FLUSH, BUSY=0 from the DEPTH-th rising edge onward.
- Output values during RST: BUSY=1, all Q=INIT_VAL.
- Reset mid-sweep: restarts at cnt=0. Partially cleared contents are irrelevant because Q is masked.
- No handshake on FLUSH. A multi-cycle FLUSH keeps restarting the sweep, so BUSY stays high until DEPTH edges after FLUSH deasserts.

## Test plan
- Reset clear, default params:
  - Pre-fill all 32 entries with 2'b11 via backdoor, then pulse RST and release.
  - BUSY=1 and Q=0 on all ports for 32 edges; BUSY=0 after the 32nd.
  - Every address then reads 2'b00.
- Write/read, 3 ports:
  - After clear, write AW=5 DI=2'b10, then AW=31 DI=2'b01.
  - Next cycle, RA={31,5,5} gives Q={01,10,10}; a port reading address 0 shows 00.
- Bypass:
  - BYPASS=1: WEN=1 AW=7 DI=2'b11 with RA0=7 gives Q0=11 in the same cycle, while RA1=8 gives the old value.
  - BYPASS=0 under the same stimulus: Q0 shows the old value, and 11 appears the following cycle.
- Flush interactions:
  - FLUSH with WEN=1 AW=3 DI=2'b11 in the same cycle: the write is dropped and the sweep runs for 32 cycles.
  - A second FLUSH 10 cycles into the sweep extends BUSY to 32 edges after that FLUSH.
  - Writes issued while BUSY=1 have no effect.
- Non-power-of-two DEPTH=20, WIDTH=8, RD_PORTS=4, INIT_VAL=8'hA5:
  - The sweep lasts 20 edges.
  - A write to AW=25 is dropped, and RA=25 reads 8'hA5.
- Reset mid-sweep: assert RST at cnt=12 and release; BUSY stays high for a full 32 edges from release.
